// File: rtl/digclk_core_param_if.sv
`timescale 1ns/1ps
// digclk_core_param_if
//   Bundles the button/mode inputs and the time/strobe outputs of the
//   timekeeping core. Clock and reset stay plain ports on the core.
//   master : board-side driver (buttons, mode select), reads the time
//   slave  : the core itself
//   incr_pb, decr_pb  raw asynchronous push-buttons
//   set_mode[1:0]     00 run, 01 set sec, 10 set min, 11 set hour
//   sec_out[5:0], min_out[5:0], hour_out[4:0], pm_out
//   tick_out          1-cycle strobe per prescaler terminal count
//   day_out           1-cycle strobe on midnight rollover
interface digclk_core_param_if;
    logic       incr_pb;
    logic       decr_pb;
    logic [1:0] set_mode;
    logic [5:0] sec_out;
    logic [5:0] min_out;
    logic [4:0] hour_out;
    logic       pm_out;
    logic       tick_out;
    logic       day_out;

    modport master (
        output incr_pb, decr_pb, set_mode,
        input  sec_out, min_out, hour_out, pm_out, tick_out, day_out
    );

    modport slave (
        input  incr_pb, decr_pb, set_mode,
        output sec_out, min_out, hour_out, pm_out, tick_out, day_out
    );
endinterface

// File: rtl/digclk_core_param.sv
`timescale 1ns/1ps
// digclk_core_param
//   HH:MM:SS timekeeping core running on the board clock. A prescaler
//   divides clk_in down to TICK_HZ; debounced inc/dec buttons adjust one
//   field at a time in the set modes; hours are shown in 24h or 12h form.
//   Ports:
//     clk_in  system clock, rising edge
//     reset   asynchronous, active-low
//     bus     digclk_core_param_if.slave (buttons, mode, time, strobes)
module digclk_core_param #(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned TICK_HZ  = 1,
    parameter int unsigned DEB_CYC  = 1_000_000,
    parameter bit          MODE_12H = 1'b0
) (
    input  logic                 clk_in,
    input  logic                 reset,
    digclk_core_param_if.slave   bus
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW = $clog2(DEB_CYC);
    localparam logic [PW-1:0] PRESC_TOP = PW'(DIV - 1);
    localparam logic [DW-1:0] DEB_TOP   = DW'(DEB_CYC - 1);

    typedef enum logic [1:0] {
        MODE_RUN      = 2'b00,
        MODE_SET_SEC  = 2'b01,
        MODE_SET_MIN  = 2'b10,
        MODE_SET_HOUR = 2'b11
    } mode_e;

    function automatic logic [5:0] wrap_up(input logic [5:0] v, input logic [5:0] top);
        return (v == top) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] wrap_dn(input logic [5:0] v, input logic [5:0] top);
        return (v == 6'd0) ? top : v - 6'd1;
    endfunction

    function automatic logic [5:0] step_field(input logic [5:0] v, input logic [5:0] top,
                                              input logic up);
        return up ? wrap_up(v, top) : wrap_dn(v, top);
    endfunction

    logic [PW-1:0]      presc_q, presc_d;
    logic               tick;
    logic [1:0]         inc_sync_q, dec_sync_q;
    logic [1:0]         mode_s1_q, mode_s2_q;
    mode_e              mode;
    logic [1:0]         btn_s;
    logic [1:0]         lvl_q, lvl_d;
    logic [1:0]         press_q, press_d;
    logic [1:0][DW-1:0] cnt_q, cnt_d;
    logic [5:0]         sec_q, sec_d, min_q, min_d;
    logic [4:0]         hour_q, hour_d;
    logic               day_q, day_d;
    logic               step_en, step_up;
    logic [4:0]         hour_disp;
    logic               pm_disp;

    assign tick    = (presc_q == PRESC_TOP);
    assign presc_d = tick ? '0 : presc_q + PW'(1);
    assign mode    = mode_e'(mode_s2_q);
    // bit 0 = increment button, bit 1 = decrement button
    assign btn_s   = {dec_sync_q[1], inc_sync_q[1]};

    // Debounce: a level differing from the accepted one must persist for
    // DEB_CYC consecutive cycles; any return to the accepted level restarts
    // the count. Only the accepted 0->1 edge produces a press pulse.
    always_comb begin
        lvl_d   = lvl_q;
        cnt_d   = cnt_q;
        press_d = 2'b00;
        for (int b = 0; b < 2; b++) begin
            if (btn_s[b] == lvl_q[b]) begin
                cnt_d[b] = '0;
            end else if (cnt_q[b] == DEB_TOP) begin
                lvl_d[b]   = btn_s[b];
                cnt_d[b]   = '0;
                press_d[b] = btn_s[b];
            end else begin
                cnt_d[b] = cnt_q[b] + DW'(1);
            end
        end
    end

    // Simultaneous inc and dec presses cancel out.
    assign step_en = press_q[0] ^ press_q[1];
    assign step_up = press_q[0];

    always_comb begin
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        day_d  = 1'b0;
        case (mode)
            MODE_RUN: begin
                if (tick) begin
                    sec_d = wrap_up(sec_q, 6'd59);
                    if (sec_q == 6'd59) begin
                        min_d = wrap_up(min_q, 6'd59);
                        if (min_q == 6'd59) begin
                            hour_d = 5'(wrap_up({1'b0, hour_q}, 6'd23));
                            day_d  = (hour_q == 5'd23);
                        end
                    end
                end
            end
            MODE_SET_SEC: begin
                if (step_en) sec_d = step_field(sec_q, 6'd59, step_up);
            end
            MODE_SET_MIN: begin
                if (step_en) min_d = step_field(min_q, 6'd59, step_up);
            end
            MODE_SET_HOUR: begin
                if (step_en) hour_d = 5'(step_field({1'b0, hour_q}, 6'd23, step_up));
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            presc_q    <= '0;
            inc_sync_q <= 2'b00;
            dec_sync_q <= 2'b00;
            mode_s1_q  <= 2'b00;
            mode_s2_q  <= 2'b00;
            lvl_q      <= 2'b00;
            cnt_q      <= '0;
            press_q    <= 2'b00;
            sec_q      <= 6'd0;
            min_q      <= 6'd0;
            hour_q     <= 5'd0;
            day_q      <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            inc_sync_q <= {inc_sync_q[0], bus.incr_pb};
            dec_sync_q <= {dec_sync_q[0], bus.decr_pb};
            mode_s1_q  <= bus.set_mode;
            mode_s2_q  <= mode_s1_q;
            lvl_q      <= lvl_d;
            cnt_q      <= cnt_d;
            press_q    <= press_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            day_q      <= day_d;
        end
    end

    // Hour display: hour_q always holds 0..23; 12h form maps 0 and 12 to 12.
    always_comb begin
        hour_disp = hour_q;
        pm_disp   = 1'b0;
        if (MODE_12H) begin
            pm_disp   = (hour_q >= 5'd12);
            hour_disp = pm_disp ? hour_q - 5'd12 : hour_q;
            if (hour_disp == 5'd0) hour_disp = 5'd12;
        end
    end

    assign bus.sec_out  = sec_q;
    assign bus.min_out  = min_q;
    assign bus.hour_out = hour_disp;
    assign bus.pm_out   = pm_disp;
    assign bus.tick_out = tick;
    assign bus.day_out  = day_q;

endmodule
